// File: rtl/instr_packer.sv
// Immediate packer between the program-load source and the instruction RAM write port.
// Range-checks each immediate against its format, packs it, and writes sequential addresses.
module instr_packer #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_fields,
    input  logic [7:0]        in_imm,
    input  logic [1:0]        in_fmt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_count,
    output logic [ADDR_W:0]   words_written
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [1:0] FMT_U3  = 2'b00;
    localparam logic [1:0] FMT_U4  = 2'b01;
    localparam logic [1:0] FMT_S5  = 2'b10;
    localparam logic [1:0] FMT_MOV = 2'b11;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] ptr;

    logic              xfer;
    logic              imm_legal;
    logic              write_ok;
    logic              write_bad;
    logic [DATA_W-1:0] packed_word;

    assign in_ready  = (state == S_LOAD) && !start;
    assign xfer      = in_valid && in_ready;
    assign write_ok  = xfer && imm_legal;
    assign write_bad = xfer && !imm_legal;
    assign full      = (state == S_FULL);

    // Immediate range check and field placement per format
    always_comb begin
        imm_legal   = 1'b0;
        packed_word = in_fields;
        case (in_fmt)
            FMT_U3: begin
                imm_legal   = (in_imm[7:3] == 5'd0);
                packed_word = {in_fields[7:5], in_imm[2:0], in_fields[1:0]};
            end
            FMT_U4: begin
                imm_legal   = (in_imm[7:4] == 4'd0);
                packed_word = {in_fields[7:4], in_imm[3:0]};
            end
            FMT_S5: begin
                imm_legal   = (in_imm[7:4] == {4{in_imm[4]}});
                packed_word = {in_fields[7:5], in_imm[4:0]};
            end
            FMT_MOV: begin
                imm_legal   = (in_imm == 8'd0);
                packed_word = in_fields;
            end
            default: begin
                imm_legal   = 1'b0;
                packed_word = in_fields;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start restarts from any state; LOAD ends on the write of the last address
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = S_LOAD;
        end else begin
            case (state)
                S_IDLE:  state_next = S_IDLE;
                S_LOAD:  if (write_ok && (ptr == LAST_ADDR)) state_next = S_FULL;
                S_FULL:  state_next = S_FULL;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            ptr           <= '0;
            words_written <= '0;
        end else begin
            mem_we <= write_ok;
            if (start) begin
                ptr           <= '0;
                words_written <= '0;
            end else if (write_ok) begin
                mem_addr      <= ptr;
                mem_wdata     <= packed_word;
                ptr           <= ptr + ADDR_W'(1);
                words_written <= words_written + (ADDR_W+1)'(1);
            end
        end
    end

    // Rejected-word tracking; count saturates rather than wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (start) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (write_bad) begin
            err <= 1'b1;
            if (err_count != CNT_MAX) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer: vector table, reference model and write scoreboard.
module tb_instr_packer;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_fields;
    logic [7:0]        in_imm;
    logic [1:0]        in_fmt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              full;
    logic              err;
    logic [7:0]        err_count;
    logic [ADDR_W:0]   words_written;

    instr_packer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_fields(in_fields), .in_imm(in_imm), .in_fmt(in_fmt),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .full(full),
        .err(err), .err_count(err_count), .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] fields;
        logic [7:0] imm;
        logic [1:0] fmt;
        logic       we;
        logic [7:0] wdata;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
        logic [7:0]        imm;
        logic [1:0]        fmt;
    } wr_t;

    wr_t sb[$];

    int passed = 0;
    int total  = 0;

    // reference model: 0 idle, 1 load, 2 full
    int          m_state;
    int          m_ptr;
    int          m_err;
    int          m_cnt;
    int          m_ww;
    logic        m_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_err = 0; m_cnt = 0; m_ww = 0; m_we = 1'b0;
        sb.delete();
    endtask

    function automatic logic [7:0] decode_imm(input logic [7:0] w, input logic [1:0] fm);
        case (fm)
            2'b00:   return {5'd0, w[4:2]};
            2'b01:   return {4'd0, w[3:0]};
            2'b10:   return {{3{w[4]}}, w[4:0]};
            default: return 8'd0;
        endcase
    endfunction

    // One clock: drive inputs, update model, compare registered outputs after the edge
    task automatic step(input logic s, input logic v, input logic [7:0] f,
                        input logic [7:0] i, input logic [1:0] fm);
        logic       rdy;
        logic       legal;
        logic [7:0] pk;
        wr_t        e;
        start = s; in_valid = v; in_fields = f; in_imm = i; in_fmt = fm;
        #1;
        rdy = (m_state == 1) && !s;
        check("in_ready", 32'(in_ready), 32'(rdy));
        case (fm)
            2'b00:   begin legal = (i[7:3] == 5'd0); pk = {f[7:5], i[2:0], f[1:0]}; end
            2'b01:   begin legal = (i[7:4] == 4'd0); pk = {f[7:4], i[3:0]}; end
            2'b10:   begin legal = (i[7:4] == 4'h0) || (i[7:4] == 4'hF); pk = {f[7:5], i[4:0]}; end
            default: begin legal = (i == 8'd0); pk = f; end
        endcase
        m_we = 1'b0;
        if (s) begin
            m_state = 1; m_ptr = 0; m_err = 0; m_cnt = 0; m_ww = 0;
        end else if (v && rdy) begin
            if (legal) begin
                e.addr = ADDR_W'(m_ptr); e.wdata = pk; e.imm = i; e.fmt = fm;
                sb.push_back(e);
                m_we = 1'b1;
                if (m_ptr == DEPTH - 1) m_state = 2;
                m_ptr = (m_ptr + 1) % DEPTH;
                m_ww++;
            end else begin
                m_err = 1;
                if (m_cnt != 255) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0; in_valid = 1'b0;
        check("mem_we", 32'(mem_we), 32'(m_we));
        check("err", 32'(err), 32'(m_err));
        check("err_count", 32'(err_count), 32'(m_cnt));
        check("words_written", 32'(words_written), 32'(m_ww));
        check("full", 32'(full), 32'(m_state == 2));
        if (mem_we) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(e.addr));
                check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                check("imm_roundtrip", 32'(decode_imm(mem_wdata, e.fmt)), 32'(e.imm));
            end
        end
    endtask

    vec_t tbl[12];

    initial begin
        logic [1:0] fm;
        logic [7:0] im;

        tbl[0]  = '{8'hE3, 8'h05, 2'b00, 1'b1, 8'hF7};
        tbl[1]  = '{8'h40, 8'hF0, 2'b10, 1'b1, 8'h50};
        tbl[2]  = '{8'h40, 8'h10, 2'b10, 1'b0, 8'h00};
        tbl[3]  = '{8'hA0, 8'h0F, 2'b01, 1'b1, 8'hAF};
        tbl[4]  = '{8'hA0, 8'h10, 2'b01, 1'b0, 8'h00};
        tbl[5]  = '{8'h5A, 8'h00, 2'b11, 1'b1, 8'h5A};
        tbl[6]  = '{8'h5A, 8'h01, 2'b11, 1'b0, 8'h00};
        tbl[7]  = '{8'hE3, 8'h08, 2'b00, 1'b0, 8'h00};
        tbl[8]  = '{8'hE3, 8'h07, 2'b00, 1'b1, 8'hFF};
        tbl[9]  = '{8'h00, 8'h0F, 2'b10, 1'b1, 8'h0F};
        tbl[10] = '{8'hFF, 8'hFF, 2'b10, 1'b1, 8'hFF};
        tbl[11] = '{8'h00, 8'hEF, 2'b10, 1'b0, 8'h00};

        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_fields = 8'd0; in_imm = 8'd0; in_fmt = 2'd0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_mem_we", 32'(mem_we), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        check("rst_full", 32'(full), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_err_count", 32'(err_count), 32'(0));
        check("rst_words_written", 32'(words_written), 32'(0));
        reset_n = 1'b1;

        // IDLE ignores valid words
        step(1'b0, 1'b1, 8'hE3, 8'h05, 2'b00);

        // Vector table
        step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, tbl[k].fields, tbl[k].imm, tbl[k].fmt);
            check("tbl_we", 32'(mem_we), 32'(tbl[k].we));
            if (tbl[k].we) check("tbl_wdata", 32'(mem_wdata), 32'(tbl[k].wdata));
        end

        // Fill all addresses back to back, then a 33rd word
        step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b0, 1'b1, 8'(k * 7), 8'(k % 16), 2'b01);
        end
        check("full_after_32", 32'(full), 32'(1));
        check("words_32", 32'(words_written), 32'(32));
        step(1'b0, 1'b1, 8'h11, 8'h01, 2'b01);
        step(1'b0, 1'b1, 8'h11, 8'h01, 2'b01);

        // Error-count saturation, then restart
        step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
        for (int k = 0; k < 300; k++) begin
            step(1'b0, 1'b1, 8'h00, 8'h20, 2'b01);
        end
        check("err_sat", 32'(err_count), 32'(255));
        step(1'b1, 1'b1, 8'h00, 8'h01, 2'b01);
        check("restart_err", 32'(err), 32'(0));
        check("restart_cnt", 32'(err_count), 32'(0));
        step(1'b0, 1'b1, 8'h30, 8'h02, 2'b01);
        check("restart_addr0", 32'(mem_addr), 32'(0));

        // Random legal words with gaps; one start with a valid word mid-stream
        for (int k = 0; k < 60; k++) begin
            fm = 2'($urandom_range(0, 3));
            case (fm)
                2'b00:   im = 8'($urandom_range(0, 7));
                2'b01:   im = 8'($urandom_range(0, 15));
                2'b10:   im = 8'($urandom_range(0, 31)) - 8'd16;
                default: im = 8'd0;
            endcase
            step(k == 25, 1'($urandom_range(0, 1)) || (k == 25), 8'($urandom_range(0, 255)), im, fm);
        end

        // Reset with a write on the bus drops it immediately
        step(1'b0, 1'b1, 8'h80, 8'h03, 2'b00);
        step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
        step(1'b0, 1'b1, 8'h80, 8'h03, 2'b00);
        check("pre_reset_we", 32'(mem_we), 32'(1));
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_we", 32'(mem_we), 32'(0));
        check("async_rst_ww", 32'(words_written), 32'(0));
        check("async_rst_addr", 32'(mem_addr), 32'(0));
        check("async_rst_wdata", 32'(mem_wdata), 32'(0));
        model_reset();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 8'h80, 8'h03, 2'b00);

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
